// File: rtl/a2d_pkg.sv
// a2d_pkg: shared state encoding, SPI frame layout and command-frame builder for the scanning A2D interface.
package a2d_pkg;
  typedef enum logic [2:0] {IDLE, CMD, GAP, RD, ACC, UPD} state_t;
  localparam int FRAME_W = 16;
  localparam int CMD_CH_LSB = 11;
  localparam int CMD_CH_W = 3;
  function automatic logic [FRAME_W-1:0] build_frame(input logic [CMD_CH_W-1:0] ch);
    build_frame = '0;
    build_frame[CMD_CH_LSB +: CMD_CH_W] = ch;
  endfunction
endpackage

// File: rtl/a2d_spi_xfer.sv
// a2d_spi_xfer: one 16-bit SPI transfer per wrt, SCLK idling high, MOSI on fall, MISO on rise.
module a2d_spi_xfer
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt,
  input  logic [FRAME_W-1:0] cmd,
  output logic               done,
  output logic [FRAME_W-1:0] rx,
  output logic               SS_n,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO
);
  localparam int P = 1 << SCLK_DIV_LOG2;
  localparam int H = P / 2;
  localparam int CW = SCLK_DIV_LOG2 + 5;
  localparam logic [CW-1:0] LAST = CW'(17 * P - 1);
  localparam logic [CW-1:0] LO_B = CW'(H);
  localparam logic [CW-1:0] LO_E = CW'(H + 16 * P);
  localparam logic [CW-1:0] RI_B = CW'(P);
  localparam logic [CW-1:0] RI_E = CW'(16 * P);
  localparam logic [SCLK_DIV_LOG2-1:0] PH_H = SCLK_DIV_LOG2'(H);
  logic active, low_n, fall_n, rise_n;
  logic [CW-1:0] cnt, nc;
  logic [FRAME_W-1:0] tx;
  // SCLK is low in the second half of each P-clk slot, i.e. when bit SCLK_DIV_LOG2-1 of the count is set
  assign nc = cnt + CW'(1);
  assign low_n = nc >= LO_B && nc < LO_E && nc[SCLK_DIV_LOG2-1];
  assign fall_n = nc >= LO_B && nc < LO_E && nc[SCLK_DIV_LOG2-1:0] == PH_H;
  assign rise_n = nc >= RI_B && nc <= RI_E && nc[SCLK_DIV_LOG2-1:0] == '0;
  assign done = active && cnt == LAST;
  assign SS_n = !active;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt <= '0;
      tx <= '0;
      rx <= '0;
      SCLK <= 1'b1;
      MOSI <= 1'b0;
    end else if (!active) begin
      if (wrt) begin
        active <= 1'b1;
        cnt <= '0;
        tx <= cmd;
      end
    end else if (done) begin
      active <= 1'b0;
      SCLK <= 1'b1;
      MOSI <= 1'b0;
    end else begin
      cnt <= nc;
      SCLK <= !low_n;
      if (fall_n) begin
        MOSI <= tx[FRAME_W-1];
        tx <= {tx[FRAME_W-2:0], 1'b0};
      end
      if (rise_n) rx <= {rx[FRAME_W-2:0], MISO};
    end
  end
endmodule

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: single-shot and round-robin scanning SPI A2D front end with oversampling and a per-channel result bank.
module a2d_scan_intf
  import a2d_pkg::*;
#(
  parameter int NUM_CHNNL = 8,
  parameter int RES_W = 12,
  parameter int SCLK_DIV_LOG2 = 5,
  parameter int AVG_LOG2 = 0,
  localparam int CH_W = NUM_CHNNL > 1 ? $clog2(NUM_CHNNL) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 strt_cnv,
  input  logic [CH_W-1:0]      chnnl,
  input  logic                 scan_en,
  input  logic [NUM_CHNNL-1:0] chnnl_mask,
  input  logic [CH_W-1:0]      rd_chnnl,
  output logic [RES_W-1:0]     rd_res,
  output logic [RES_W-1:0]     res,
  output logic [CH_W-1:0]      res_chnnl,
  output logic                 cnv_cmplt,
  output logic                 busy,
  output logic [NUM_CHNNL-1:0] rslt_vld,
  output logic                 a2d_SS_n,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO
);
  localparam int AW = RES_W + AVG_LOG2;
  localparam int SW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  state_t state, nstate;
  logic [CH_W-1:0] ch, ptr, nxt, sel_ch;
  logic [AW-1:0] acc;
  logic [SW-1:0] smp;
  logic [RES_W-1:0] bank [NUM_CHNNL];
  logic [RES_W-1:0] avg;
  logic go_s, go_scan, more, wrt, done, unused_rx;
  logic [FRAME_W-1:0] cmd, rx;
  a2d_spi_xfer #(.SCLK_DIV_LOG2(SCLK_DIV_LOG2)) u_xfer (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .done(done), .rx(rx),
    .SS_n(a2d_SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );
  assign unused_rx = ^(rx >> RES_W);
  assign avg = RES_W'(acc >> AVG_LOG2);
  assign busy = state != IDLE;
  assign rd_res = int'(rd_chnnl) < NUM_CHNNL ? bank[rd_chnnl] : '0;
  assign cmd = build_frame(CMD_CH_W'(sel_ch));
  // first enabled channel strictly after the last scanned one, wrapping; the loop runs downward so the nearest wins
  always_comb begin
    nxt = ptr;
    for (int k = NUM_CHNNL; k >= 1; k--)
      if (chnnl_mask[(int'(ptr) + k) % NUM_CHNNL]) nxt = CH_W'((int'(ptr) + k) % NUM_CHNNL);
  end
  // the transfer is launched in the cycle that enters CMD/RD so the engine never waits on the FSM
  always_comb begin
    go_s = strt_cnv && (int'(chnnl) < NUM_CHNNL);
    go_scan = scan_en && |chnnl_mask;
    more = int'(smp) < (1 << AVG_LOG2) - 1;
    sel_ch = state == IDLE ? (go_s ? chnnl : nxt) : ch;
    wrt = (state == IDLE && (go_s || go_scan)) || state == GAP || (state == ACC && more);
    nstate = state;
    case (state)
      IDLE: nstate = (go_s || go_scan) ? CMD : IDLE;
      CMD:  nstate = done ? GAP : CMD;
      GAP:  nstate = RD;
      RD:   nstate = done ? ACC : RD;
      ACC:  nstate = more ? CMD : UPD;
      UPD:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ch <= '0;
      ptr <= '0;
      acc <= '0;
      smp <= '0;
      res <= '0;
      res_chnnl <= '0;
      cnv_cmplt <= 1'b0;
      rslt_vld <= '0;
      for (int i = 0; i < NUM_CHNNL; i++) bank[i] <= '0;
    end else begin
      state <= nstate;
      cnv_cmplt <= state == UPD;
      if (state == IDLE && (go_s || go_scan)) begin
        ch <= sel_ch;
        smp <= '0;
        if (!go_s) ptr <= nxt;
      end
      if (state == ACC) begin
        acc <= acc + AW'(rx[RES_W-1:0]);
        smp <= smp + SW'(1);
      end
      if (state == UPD) begin
        bank[ch] <= avg;
        res <= avg;
        res_chnnl <= ch;
        rslt_vld[ch] <= 1'b1;
        acc <= '0;
      end
    end
  end
endmodule
